// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall and redirect flush sequencer; HAZARD_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic                  id_rs_used,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rt_used,
  input  logic                  dx_valid,
  input  logic                  dx_mem_read,
  input  logic [REG_ADDR_W-1:0] dx_rd,
  input  logic                  ex_redirect,
  input  logic                  halt_req,
  output logic                  stall,
  output logic                  pc_write_en,
  output logic                  dx_bubble,
  output logic                  flush,
  output logic                  flush_again,
  output logic                  flush_final,
  output logic                  halted,
  output logic [15:0]           stall_cnt,
  output logic [15:0]           flush_cnt
);
  typedef enum logic [2:0] {IDLE, STALL, FL1, FL2, FL3, HALT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_cnt, w_cnt_next;
  logic w_hz;
  assign w_hz = id_valid & dx_valid & dx_mem_read &
                ((id_rs_used & (id_rs == dx_rd)) | (id_rt_used & (id_rt == dx_rd)));
  assign pc_write_en = ~stall;
  // state and remaining-stall counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end
  // next state and control outputs; redirect outranks hazard, hazard outranks halt
  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt;
    stall       = 1'b0;
    dx_bubble   = 1'b0;
    flush       = 1'b0;
    flush_again = 1'b0;
    flush_final = 1'b0;
    halted      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_redirect) w_next = FL1;
        else if (w_hz) begin
          stall     = 1'b1;
          dx_bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_next     = STALL;
            w_cnt_next = 2'(LOAD_STALL_CYCLES - 1);
          end
        end else if (halt_req) w_next = HALT;
      end
      STALL: begin
        stall      = 1'b1;
        dx_bubble  = 1'b1;
        w_cnt_next = r_cnt - 2'd1;
        w_next     = ex_redirect ? FL1 : (r_cnt == 2'd1 ? IDLE : STALL);
      end
      FL1: begin
        flush  = 1'b1;
        w_next = FL2;
      end
      FL2: begin
        flush_again = 1'b1;
        w_next      = FL3;
      end
      FL3: begin
        flush_final = 1'b1;
        w_next      = IDLE;
      end
      HALT: begin
        halted = 1'b1;
        stall  = 1'b1;
      end
      default: w_next = IDLE;
    endcase
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_stall_cnt, r_flush_cnt;
  // saturating counts of non-halt stall cycles and flush-sequence entries
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && r_state != HALT && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_next == FL1 && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl with LOAD_STALL_CYCLES=2
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b1, id_rs_used = 1'b1, id_rt_used = 1'b0;
  logic [2:0] id_rs = 3'd3, id_rt = 3'd5, dx_rd = 3'd3;
  logic dx_valid = 1'b1, dx_mem_read = 1'b0, ex_redirect = 1'b0, halt_req = 1'b0;
  logic stall, pc_write_en, dx_bubble, flush, flush_again, flush_final, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0] obs;
  int checks = 0;
  int errors = 0;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [6:0] I = 7'b0100000, S = 7'b1010000, F1 = 7'b0101000,
                         F2 = 7'b0100100, F3 = 7'b0100010, H = 7'b1000001;
  assign obs = {stall, pc_write_en, dx_bubble, flush, flush_again, flush_final, halted};
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(2), .REG_ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used), .dx_valid(dx_valid), .dx_mem_read(dx_mem_read),
    .dx_rd(dx_rd), .ex_redirect(ex_redirect), .halt_req(halt_req), .stall(stall),
    .pc_write_en(pc_write_en), .dx_bubble(dx_bubble), .flush(flush), .flush_again(flush_again),
    .flush_final(flush_final), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic step(input logic red, input logic ld, input logic hlt);
    @(negedge clk);
    ex_redirect = red;
    dx_mem_read = ld;
    halt_req = hlt;
    #1;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ex_redirect = 1'b0;
    dx_mem_read = 1'b0;
    halt_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== I) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs, I); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %h/%h exp 0000/0000", stall_cnt, flush_cnt);
    end
    step(0, 0, 0);
    checks++;
    if (obs !== I) begin errors++; $display("FAIL idle_outputs: got %b exp %b", obs, I); end
  endtask
  task automatic test_load_use();
    logic [6:0] ex[3] = '{S, S, I};
    for (int i = 0; i < 3; i++) begin
      step(0, i == 0, 0);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL load_use_rs[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
    id_rs = 3'd1; id_rs_used = 1'b0; id_rt = 3'd3; id_rt_used = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, i == 0, 0);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL load_use_rt[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
    id_rs = 3'd3; id_rt = 3'd5; id_rt_used = 1'b0;
    step(0, 1, 0);
    checks++;
    if (obs !== I) begin errors++; $display("FAIL rs_unused: got %b exp %b", obs, I); end
    id_rs_used = 1'b1; dx_valid = 1'b0;
    step(0, 1, 0);
    checks++;
    if (obs !== I) begin errors++; $display("FAIL dx_invalid: got %b exp %b", obs, I); end
    dx_valid = 1'b1; dx_rd = 3'd4;
    step(0, 1, 0);
    checks++;
    if (obs !== I) begin errors++; $display("FAIL rd_mismatch: got %b exp %b", obs, I); end
    dx_rd = 3'd3;
    step(0, 0, 0);
  endtask
  task automatic test_flush();
    logic [2:0] in[5] = '{3'b100, 3'b000, 3'b100, 3'b000, 3'b000};
    logic [6:0] ex[5] = '{I, F1, F2, F3, I};
    for (int i = 0; i < 5; i++) begin
      step(in[i][2], in[i][1], in[i][0]);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL flush_seq[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
  endtask
  task automatic test_redirect_hz();
    logic [2:0] in[5] = '{3'b110, 3'b010, 3'b011, 3'b000, 3'b000};
    logic [6:0] ex[5] = '{I, F1, F2, F3, I};
    for (int i = 0; i < 5; i++) begin
      step(in[i][2], in[i][1], in[i][0]);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL redirect_hz[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
  endtask
  task automatic test_stall_abort();
    logic [2:0] in[6] = '{3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [6:0] ex[6] = '{S, S, F1, F2, F3, I};
    for (int i = 0; i < 6; i++) begin
      step(in[i][2], in[i][1], in[i][0]);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL stall_abort[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
  endtask
  task automatic test_halt();
    logic [2:0] in[7] = '{3'b011, 3'b001, 3'b001, 3'b000, 3'b010, 3'b100, 3'b001};
    logic [6:0] ex[7] = '{S, S, I, H, H, H, H};
    for (int i = 0; i < 7; i++) begin
      step(in[i][2], in[i][1], in[i][0]);
      checks++;
      if (obs !== ex[i]) begin errors++; $display("FAIL halt_seq[%0d]: got %b exp %b", i, obs, ex[i]); end
    end
    do_reset();
    checks++;
    if (obs !== I) begin errors++; $display("FAIL halt_reset: got %b exp %b", obs, I); end
    step(1, 0, 0);
    step(0, 0, 0);
    do_reset();
    checks++;
    if (obs !== I) begin errors++; $display("FAIL flush_reset: got %b exp %b", obs, I); end
    step(0, 0, 0);
    checks++;
    if (obs !== I) begin errors++; $display("FAIL flush_abandoned: got %b exp %b", obs, I); end
  endtask
  task automatic test_perf();
    logic [2:0] in[15] = '{3'b010, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000,
                           3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000};
    do_reset();
    for (int i = 0; i < 15; i++) step(in[i][2], in[i][1], in[i][0]);
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (stall_cnt !== (PERF ? 16'd4 : 16'd0)) begin
      errors++; $display("FAIL perf_stall_cnt: got %0d exp %0d", stall_cnt, PERF ? 4 : 0);
    end
    checks++;
    if (flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL perf_flush_cnt: got %0d exp %0d", flush_cnt, PERF ? 2 : 0);
    end
`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    for (int i = 0; i < 65540; i++) step(0, 1, 0);
    checks++;
    if (stall_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL perf_saturate: got %h exp ffff", stall_cnt);
    end
`endif
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_flush();
    test_redirect_hz();
    test_stall_abort();
    test_halt();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
